// File: rtl/cordic_dispatch_pkg.sv
// cordic_dispatch_pkg: mode and result-code constants, controller state
// encoding and the mode decoder shared by the CORDIC dispatch controller.
package cordic_dispatch_pkg;

  localparam int ENG_IDX_W = 3;

  // Mode field values. The suffix names the engine slot that serves the mode.
  localparam logic [7:0] MODE_E0      = 8'd1;
  localparam logic [7:0] MODE_E0_SEC  = 8'd9;
  localparam logic [7:0] MODE_E1      = 8'd2;
  localparam logic [7:0] MODE_E1_SEC  = 8'd10;
  localparam logic [7:0] MODE_E2      = 8'd3;
  localparam logic [7:0] MODE_E3      = 8'd4;
  localparam logic [7:0] MODE_E3_SEC  = 8'd11;
  localparam logic [7:0] MODE_E4      = 8'd5;
  localparam logic [7:0] MODE_E5      = 8'd6;
  localparam logic [7:0] MODE_E6      = 8'd7;
  localparam logic [7:0] MODE_E7_2OP  = 8'd8;

  // Result codes carried in the upper 16 bits of each output frame.
  localparam logic [15:0] RC_0A      = 16'h000A;
  localparam logic [15:0] RC_0B      = 16'h000B;
  localparam logic [15:0] RC_0C      = 16'h000C;
  localparam logic [15:0] RC_0D      = 16'h000D;
  localparam logic [15:0] RC_0E      = 16'h000E;
  localparam logic [15:0] RC_0F      = 16'h000F;
  localparam logic [15:0] RC_TIMEOUT = 16'h00FE;
  localparam logic [15:0] RC_INVALID = 16'h00FF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_WAIT,
    S_DECODE,
    S_B_REQ,
    S_B_WAIT,
    S_B_LATCH,
    S_RUN,
    S_WRITE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [ENG_IDX_W-1:0] eng_idx;
    logic                 res_sel;  // 0: primary result, 1: secondary
    logic                 two_op;
    logic [15:0]          code;
  } dec_t;

  // Map a mode byte to engine slot, result port, operand count and code.
  function automatic dec_t decode_mode(input logic [7:0] mode);
    dec_t d;
    d       = '0;
    d.valid = 1'b1;
    case (mode)
      MODE_E0:     begin d.eng_idx = 3'd0; d.code = RC_0A; end
      MODE_E0_SEC: begin d.eng_idx = 3'd0; d.res_sel = 1'b1; d.code = RC_0C; end
      MODE_E1:     begin d.eng_idx = 3'd1; d.code = RC_0A; end
      MODE_E1_SEC: begin d.eng_idx = 3'd1; d.res_sel = 1'b1; d.code = RC_0C; end
      MODE_E2:     begin d.eng_idx = 3'd2; d.code = RC_0B; end
      MODE_E3:     begin d.eng_idx = 3'd3; d.code = RC_0A; end
      MODE_E3_SEC: begin d.eng_idx = 3'd3; d.res_sel = 1'b1; d.code = RC_0C; end
      MODE_E4:     begin d.eng_idx = 3'd4; d.code = RC_0E; end
      MODE_E5:     begin d.eng_idx = 3'd5; d.code = RC_0F; end
      MODE_E6:     begin d.eng_idx = 3'd6; d.code = RC_0D; end
      MODE_E7_2OP: begin d.eng_idx = 3'd7; d.two_op = 1'b1; d.code = RC_0B; end
      default:     d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cordic_result_mux.sv
// cordic_result_mux: picks one engine's primary or secondary result out of
// the flattened per-engine result buses.
module cordic_result_mux
  import cordic_dispatch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_ENG  = 8
) (
  input  logic [N_ENG*DATA_W-1:0] i_res0,
  input  logic [N_ENG*DATA_W-1:0] i_res1,
  input  logic [ENG_IDX_W-1:0]    i_eng_idx,
  input  logic                    i_res_sel,
  output logic [DATA_W-1:0]       o_res
);

  // Slot k lives at [k*DATA_W +: DATA_W]; unmatched index yields zero.
  always_comb begin
    o_res = '0;
    for (int k = 0; k < N_ENG; k++) begin
      if (int'(i_eng_idx) == k) begin
        o_res = i_res_sel ? i_res1[k*DATA_W +: DATA_W] : i_res0[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/cordic_dispatch_ctrl.sv
// cordic_dispatch_ctrl: pops command frames, decodes the mode, gathers one or
// two operands, runs one CORDIC engine via call/done and pushes a tagged
// result frame. Invalid modes produce an 0x00FF error frame.
// Optional hang watchdog: define CORDIC_DISPATCH_WDOG_EN to abort a job that
// sees no done within TIMEOUT cycles and emit an 0x00FE error frame.
module cordic_dispatch_ctrl
  import cordic_dispatch_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int N_ENG   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_empty,
  output logic                    in_rd_en,
  input  logic [DATA_W+15:0]      in_data,
  input  logic                    out_full,
  output logic                    out_wr_en,
  output logic [DATA_W+15:0]      out_data,
  output logic                    eng_reset_n,
  output logic [N_ENG-1:0]        eng_call,
  output logic [DATA_W-1:0]       eng_a,
  output logic [DATA_W-1:0]       eng_b,
  input  logic [N_ENG-1:0]        eng_done,
  input  logic [N_ENG*DATA_W-1:0] eng_res0,
  input  logic [N_ENG*DATA_W-1:0] eng_res1,
  output logic                    busy
);

  state_t               r_state, w_nxt;
  logic                 r_alive;     // low in the first cycle after reset
  logic [7:0]           r_mode;
  logic [ENG_IDX_W-1:0] r_eng_idx;
  logic                 r_res_sel;
  logic [15:0]          r_code;
  logic [15:0]          r_err_code;
  logic [DATA_W-1:0]    r_a, r_b;
  logic [DATA_W+15:0]   r_out;

  logic [7:0]           w_mode;
  dec_t                 w_dec;
  logic                 w_dec_ok;
  logic                 w_done;
  logic                 w_tmo;
  logic [DATA_W-1:0]    w_res;
  logic                 w_unused_hi;

  assign w_mode      = in_data[DATA_W+7:DATA_W];
  assign w_dec       = decode_mode(w_mode);
  assign w_dec_ok    = w_dec.valid && (int'(w_dec.eng_idx) < N_ENG);
  assign w_unused_hi = ^in_data[DATA_W+15:DATA_W+8];

  cordic_result_mux #(
    .DATA_W (DATA_W),
    .N_ENG  (N_ENG)
  ) u_res_mux (
    .i_res0    (eng_res0),
    .i_res1    (eng_res1),
    .i_eng_idx (r_eng_idx),
    .i_res_sel (r_res_sel),
    .o_res     (w_res)
  );

`ifdef CORDIC_DISPATCH_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wdog;

  // Cycles spent in RUN for the current job; cleared outside RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              r_wdog <= '0;
    else if (r_state == S_RUN) r_wdog <= r_wdog + WD_W'(1);
    else                       r_wdog <= '0;
  end

  assign w_tmo = (r_state == S_RUN) && !w_done && (r_wdog == WD_W'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign w_tmo = 1'b0;
`endif

  // One-hot call to the selected slot while running; only its done counts.
  always_comb begin
    eng_call = '0;
    w_done   = 1'b0;
    for (int k = 0; k < N_ENG; k++) begin
      if (int'(r_eng_idx) == k) begin
        eng_call[k] = (r_state == S_RUN);
        w_done      = eng_done[k];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // Next state plus the FIFO pop/push pulses.
  always_comb begin
    w_nxt     = r_state;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!in_empty && r_alive) begin
          in_rd_en = 1'b1;
          w_nxt    = S_RD_WAIT;
        end
      end
      S_RD_WAIT: w_nxt = S_DECODE;
      S_DECODE: begin
        if (!w_dec_ok)         w_nxt = S_ERR;
        else if (w_dec.two_op) w_nxt = S_B_REQ;
        else                   w_nxt = S_RUN;
      end
      S_B_REQ: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          w_nxt    = S_B_WAIT;
        end
      end
      S_B_WAIT:  w_nxt = S_B_LATCH;
      S_B_LATCH: w_nxt = S_RUN;
      S_RUN: begin
        if (w_done)     w_nxt = S_WRITE;
        else if (w_tmo) w_nxt = S_ERR;
      end
      S_WRITE, S_ERR: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          w_nxt     = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Operand, decode and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alive    <= 1'b0;
      r_mode     <= '0;
      r_eng_idx  <= '0;
      r_res_sel  <= 1'b0;
      r_code     <= '0;
      r_err_code <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_out      <= '0;
    end else begin
      r_alive <= 1'b1;
      case (r_state)
        S_DECODE: begin
          r_mode     <= w_mode;
          r_a        <= in_data[DATA_W-1:0];
          r_b        <= '0;
          r_eng_idx  <= w_dec.eng_idx;
          r_res_sel  <= w_dec.res_sel;
          r_code     <= w_dec.code;
          r_err_code <= RC_INVALID;
        end
        S_B_LATCH: r_b <= in_data[DATA_W-1:0];
        S_RUN: begin
          if (w_done)     r_out      <= {r_code, w_res};
          else if (w_tmo) r_err_code <= RC_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  // Frame is driven only during the push cycle, zero otherwise.
  always_comb begin
    out_data = '0;
    if (out_wr_en) begin
      out_data = (r_state == S_ERR) ? {r_err_code, DATA_W'(r_mode)} : r_out;
    end
  end

  assign eng_reset_n = (r_state == S_RUN);
  assign eng_a       = r_a;
  assign eng_b       = r_b;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_cordic_dispatch_ctrl.sv
// Directed bench for cordic_dispatch_ctrl with a 1-cycle-latency FIFO model
// and hand-driven engine done/result signals.
module tb_cordic_dispatch_ctrl;
  localparam int DW = 32;
  localparam int NE = 8;
`ifdef CORDIC_DISPATCH_WDOG_EN
  localparam int TMO  = 16;
  localparam int HOLD = 12;
`else
  localparam int TMO  = 1024;
  localparam int HOLD = 20;
`endif

  logic           clk = 1'b0, reset_n = 1'b0, in_empty = 1'b1, out_full = 1'b0;
  logic           in_rd_en, out_wr_en, eng_reset_n, busy;
  logic [DW+15:0] in_data = '0, out_data, d;
  logic [NE-1:0]  eng_call, eng_done = '0;
  logic [DW-1:0]  eng_a, eng_b;
  logic [NE*DW-1:0] eng_res0 = '0, eng_res1 = '0;

  int n_chk = 0, n_err = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, call_cnt = 0;
  int at, at2, w0, r0, c0, bad;
  logic [DW+15:0] q[$];

  cordic_dispatch_ctrl #(.DATA_W(DW), .N_ENG(NE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .in_data(in_data), .out_full(out_full), .out_wr_en(out_wr_en),
    .out_data(out_data), .eng_reset_n(eng_reset_n), .eng_call(eng_call),
    .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done), .eng_res0(eng_res0),
    .eng_res1(eng_res1), .busy(busy)
  );

  always #5 clk = ~clk;

  // Input FIFO: pop presents data after the edge; empty follows occupancy.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_rd_en && q.size() > 0) in_data <= q.pop_front();
    in_empty <= (q.size() == 0);
  end

  always @(negedge clk) begin
    if (in_rd_en) begin rd_cnt++; rd_cyc = cyc; end
    if (out_wr_en) wr_cnt++;
    if (eng_call != '0) call_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] mode, input logic [DW-1:0] opd);
    q.push_back({8'h00, mode, opd});
  endtask

  task automatic wait_call(input logic [NE-1:0] exp, input string tag, output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (eng_call == exp) begin t = cyc; break; end
    end
    chk(tag, 64'(t >= 0), 64'd1);
  endtask

  task automatic wait_wr(input string tag, output logic [DW+15:0] dat, output int t);
    t = -1; dat = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_wr_en) begin t = cyc; dat = out_data; break; end
    end
    chk(tag, 64'(t >= 0), 64'd1);
  endtask

  // Raise done on slot k for one cycle with the given results.
  task automatic fire(input int k, input logic [DW-1:0] r0v, input logic [DW-1:0] r1v);
    tick();
    eng_res0[k*DW +: DW] = r0v;
    eng_res1[k*DW +: DW] = r1v;
    eng_done = '0;
    eng_done[k] = 1'b1;
    tick();
    eng_done = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_wr", {in_rd_en, out_wr_en, busy, eng_reset_n}, 4'b0000);
    chk("rst_out_data", out_data, '0);
    chk("rst_call", eng_call, '0);
    chk("rst_ab", {eng_a, eng_b}, '0);
    tick(); reset_n = 1'b1; tick();

    // 1: mode 1, engine 0 primary result
    push(8'd1, 32'h0000_4000);
    wait_call(8'h01, "t1_call", at);
    chk("t1_pop_to_run", 64'(at - rd_cyc), 64'd3);
    chk("t1_a", eng_a, 32'h0000_4000);
    chk("t1_eng_rstn", {eng_reset_n, busy}, 2'b11);
    w0 = wr_cnt; bad = 0;
    for (int i = 0; i < HOLD; i++) begin
      tick(); @(negedge clk);
      if (eng_call != 8'h01 || out_wr_en) bad++;
    end
    chk("t1_call_held", bad, 0);
    fire(0, 32'h0000_1234, 32'h0000_AAAA);
    @(negedge clk);
    chk("t1_wr", out_wr_en, 1'b1);
    chk("t1_data", out_data, {16'h000A, 32'h0000_1234});
    chk("t1_call_drop", {eng_call, eng_reset_n}, 9'h000);
    tick(); @(negedge clk);
    chk("t1_data_clr", out_data, '0);
    chk("t1_idle", busy, 1'b0);
    chk("t1_one_push", wr_cnt - w0, 1);

    // 2: two-operand mode 8, second frame's mode ignored
    r0 = rd_cnt;
    push(8'd8, 32'h0000_0100);
    push(8'h77, 32'h0000_0200);
    wait_call(8'h80, "t2_call", at);
    chk("t2_a", eng_a, 32'h0000_0100);
    chk("t2_b", eng_b, 32'h0000_0200);
    chk("t2_two_pops", rd_cnt - r0, 2);
    fire(7, 32'h0000_BEEF, 32'h0000_0000);
    @(negedge clk);
    chk("t2_data", out_data, {16'h000B, 32'h0000_BEEF});
    tick();
    chk("t2_no_extra_pop", rd_cnt - r0, 2);

    // 3: invalid mode gives an error frame and never calls an engine
    c0 = call_cnt;
    push(8'h2A, 32'h0000_DEAD);
    wait_wr("t3_wr", d, at2);
    chk("t3_data", d, {16'h00FF, 32'h0000_002A});
    tick();
    chk("t3_no_call", call_cnt - c0, 0);

    // 4: output full stall after mode 7 done
    push(8'd7, 32'h0000_0007);
    wait_call(8'h40, "t4_call", at);
    tick(); out_full = 1'b1;
    fire(6, 32'h0000_7777, 32'h0000_0000);
    w0 = wr_cnt; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_wr_en || !busy || out_data != '0) bad++;
      tick();
    end
    chk("t4_stall", bad, 0);
    out_full = 1'b0;
    @(negedge clk);
    chk("t4_wr", out_wr_en, 1'b1);
    chk("t4_data", out_data, {16'h000D, 32'h0000_7777});
    tick();
    chk("t4_one_push", wr_cnt - w0, 1);

    // 5: done from a non-selected engine is ignored
    push(8'd5, 32'h0000_0055);
    wait_call(8'h10, "t5_call", at);
    w0 = wr_cnt;
    fire(2, 32'h0000_0BAD, 32'h0000_0BAD);
    repeat (3) tick();
    @(negedge clk);
    chk("t5_still_run", {eng_call, busy}, {8'h10, 1'b1});
    chk("t5_no_push", wr_cnt - w0, 0);
    fire(4, 32'h0000_5555, 32'h0000_0000);
    @(negedge clk);
    chk("t5_data", out_data, {16'h000E, 32'h0000_5555});
    tick();

    // 6: reset during RUN drops the job; mode 9 then returns res1
    w0 = wr_cnt;
    push(8'd1, 32'h0000_0001);
    wait_call(8'h01, "t6_call", at);
    tick(); reset_n = 1'b0;
    @(negedge clk);
    chk("t6_abort", {eng_call, eng_reset_n, busy}, 10'h000);
    tick(); reset_n = 1'b1;
    repeat (5) tick();
    chk("t6_no_push", wr_cnt - w0, 0);
    push(8'd9, 32'h0000_0010);
    wait_call(8'h01, "t6b_call", at);
    fire(0, 32'h0000_1111, 32'h0000_9999);
    @(negedge clk);
    chk("t6_data", out_data, {16'h000C, 32'h0000_9999});
    tick();

`ifdef CORDIC_DISPATCH_WDOG_EN
    // 7: engine never answers; watchdog fires after TIMEOUT cycles
    push(8'd3, 32'h0000_0030);
    wait_call(8'h04, "t7_call", at);
    wait_wr("t7_wr", d, at2);
    chk("t7_data", d, {16'h00FE, 32'h0000_0003});
    chk("t7_delay", 64'(at2 - at), 64'd16);
    chk("t7_eng_held_rst", {eng_call, eng_reset_n}, 9'h000);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_dispatch_ctrl.md
Name: cordic_dispatch_ctrl

Overview:
Parametrised successor to the single-width CORDIC mode controller. Pops command frames from an input FIFO, decodes the mode field and gathers one or two operands. Drives exactly one of N_ENG external CORDIC engines through a call/done handshake, then pushes a tagged result frame into an output FIFO under backpressure. Adds invalid-mode error frames, output-full stall and an optional hang watchdog.

Parameters:
DATA_W, 32, operand/result width
N_ENG, 8, number of engine slots (engine index 0..N_ENG-1)
TIMEOUT, 1024, watchdog limit in cycles (used only with watchdog macro)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_empty  in  1  input FIFO empty
in_rd_en  out  1  input FIFO pop, one-cycle pulse
in_data  in  DATA_W+16  frame: [DATA_W+7:DATA_W] mode, [DATA_W-1:0] operand, upper 8 bits ignored
out_full  in  1  output FIFO full
out_wr_en  out  1  output FIFO push, one-cycle pulse
out_data  out  DATA_W+16  {16-bit result code, result}
eng_reset_n  out  1  engine reset, low when no job is active
eng_call  out  N_ENG  one-hot call, level-held until done
eng_a  out  DATA_W  operand A (x for two-operand modes)
eng_b  out  DATA_W  operand B (y)
eng_done  in  N_ENG  per-engine done
eng_res0  in  N_ENG*DATA_W  primary result per engine, flattened, slot k at [k*DATA_W +: DATA_W]
eng_res1  in  N_ENG*DATA_W  secondary result (cos/cosh/arccos)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0 (eng_reset_n=0). FSM is in IDLE. Asserting reset_n mid-job aborts the job and drops it silently.
- FIFO read latency is 1 cycle. in_rd_en pulses in state X. Data is sampled in the state after next.
- States and transitions:
  - IDLE: if !in_empty, pulse in_rd_en, go to RD_WAIT.
  - RD_WAIT: go to DECODE.
  - DECODE: latch mode and operand A. Invalid mode -> ERR. Two-operand mode -> B_REQ. Otherwise -> RUN.
  - B_REQ: wait for !in_empty, pulse in_rd_en, go to B_WAIT.
  - B_WAIT: go to B_LATCH.
  - B_LATCH: latch operand B, go to RUN. The second frame's mode field is ignored.
  - RUN: eng_reset_n=1 and eng_call[sel]=1. Only eng_done[sel] is observed; done from other engines is ignored. On done, latch the selected result and code, drop call and eng_reset_n the same cycle, go to WRITE.
  - WRITE: hold until !out_full. Then pulse out_wr_en with out_data valid in the same cycle and go to IDLE. out_data returns to 0 the next cycle.
  - ERR: issue error frame {16'h00FF, zero-extended mode} via the same out_full rule, go to IDLE.
- Mode table (mode: engine, result, code):
  - 1: eng0, res0, 000A
  - 9: eng0, res1, 000C
  - 2: eng1, res0, 000A
  - 10: eng1, res1, 000C
  - 3: eng2, res0, 000B
  - 4: eng3, res0, 000A
  - 11: eng3, res1, 000C
  - 5: eng4, res0, 000E
  - 6: eng5, res0, 000F
  - 7: eng6, res0, 000D
  - 8: eng7, res0, 000B, two-operand
  - Any other mode, or any mode whose engine index is >= N_ENG, is invalid.
- Minimum latency, one-operand job: pop to RUN = 3 cycles. Engine done to out_wr_en = 1 cycle when out_full=0.
- Only one job is in flight at a time. in_rd_en is never asserted outside IDLE and B_REQ.

Optional Feature:
CORDIC_DISPATCH_WDOG_EN
- Defined: a cycle counter runs in RUN. When it reaches TIMEOUT without done:
  - drop eng_call and hold eng_reset_n low for one cycle;
  - emit error frame {16'h00FE, zero-extended mode};
  - return to IDLE.
- Undefined: no counter; RUN waits indefinitely.

Decomposition:
- Package cordic_dispatch_pkg:
  - mode constants;
  - result-code constants (000A..000F, 00FE, 00FF);
  - state enum localparams;
  - decode function mode -> {valid, eng_idx, res_sel, two_op, code}.
- Sub-module: cordic_result_mux. Combinational selection of a DATA_W slice from eng_res0/eng_res1 by eng_idx and res_sel.

Test Plan:
1. Frame mode=1, operand 0x0000_4000; engine 0 returns res0 0x1234 after 20 cycles -> eng_call=8'h01 held; single out_wr_en with out_data {16'h000A, 32'h0000_1234}.
2. Mode=8 frames x=0x100 then y=0x200 -> eng_a=0x100, eng_b=0x200, eng_call=8'h80; result frame code 000B. Assert exactly two in_rd_en pulses.
3. Mode=0x2A -> out_data {16'h00FF, 32'h0000_002A}; eng_call stays 0.
4. out_full held high 10 cycles after mode=7 done -> no push during stall; push on first cycle out_full=0 with code 000D.
5. Spurious eng_done[2] during a mode=5 job -> ignored; job completes only on eng_done[4].
6. Reset pulse during RUN, then mode=9 -> no output for the aborted job; next job returns res1 with code 000C. With the watchdog macro and TIMEOUT=16, engine never done -> {16'h00FE, mode} emitted after 16 cycles.
